// File: rtl/prim_edn_prefetch_pkg.sv
// Shared types and helpers for the EDN prefetch buffer.
//
// fetch_state_e : states of the upstream fetch FSM.
// entry_t       : {fips, data} record for the default 128-bit entropy word.
//                 Modules parameterised on Width build the same layout locally.
// lvl_width()   : bit width needed to hold a fill level of 0..depth.
package prim_edn_prefetch_pkg;

  localparam int unsigned DefaultWidth = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic                    fips;
    logic [DefaultWidth-1:0] data;
  } entry_t;

  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prim_edn_prefetch_buf.sv
// Circular buffer of Depth entries, each {fips, data} packed into EntryW bits.
//
// Ports:
//   clk_i, rst_i : clock and asynchronous active-high reset
//   push_i       : write wdata_i at the tail this cycle
//   wdata_i      : entry to write
//   pop_i        : drop the head entry this cycle
//   clr_i        : empty the buffer; wins over push and pop
//   cnt_o        : number of stored entries
//   head_o       : entry at the read pointer (not masked; caller checks cnt_o)
//
// The fill level is an explicit counter so non-power-of-2 depths work.
// Storage is not reset; only pointers and count are.
module prim_edn_prefetch_buf
  import prim_edn_prefetch_pkg::*;
#(
  parameter int unsigned EntryW = 129,
  parameter int unsigned Depth  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [EntryW-1:0]              wdata_i,
  input  logic                           pop_i,
  input  logic                           clr_i,
  output logic [lvl_width(Depth)-1:0]    cnt_o,
  output logic [EntryW-1:0]              head_o
);

  localparam int unsigned CntW = lvl_width(Depth);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [EntryW-1:0] mem_q [Depth];
  logic [EntryW-1:0] mem_d [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Data storage carries no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign cnt_o  = cnt_q;
  assign head_o = mem_q[rptr_q];

endmodule

// File: rtl/prim_edn_prefetch.sv
// EDN prefetch stage: keeps up to Depth entropy words buffered so consumers
// get a word with zero extra latency instead of waiting for an EDN round trip.
//
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   edn_req_o              : registered request to the upstream gadget
//   edn_ack_i              : one-cycle ack; edn_data_i/edn_fips_i valid with it
//   edn_data_i, edn_fips_i : entropy word and its FIPS flag
//   rd_req_i               : consumer request (level)
//   rd_ack_o               : word consumed this cycle
//   rd_data_o, rd_fips_o   : head word and flag, zero when empty
//   flush_i                : drop buffered and in-flight entropy
//   lvl_o                  : number of buffered words
//   fips_err_o             : pulse after a non-FIPS word was rejected
//
// Handshakes: upstream, edn_req_o rises and stays high until the cycle
// edn_ack_i is seen; data transfers in that ack cycle. Downstream, a word
// transfers in every cycle where rd_req_i and rd_ack_o are both high.
module prim_edn_prefetch
  import prim_edn_prefetch_pkg::*;
#(
  parameter int unsigned Width         = 128,
  parameter int unsigned Depth         = 2,
  parameter bit          RejectNonFips = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        edn_req_o,
  input  logic                        edn_ack_i,
  input  logic [Width-1:0]            edn_data_i,
  input  logic                        edn_fips_i,
  input  logic                        rd_req_i,
  output logic                        rd_ack_o,
  output logic [Width-1:0]            rd_data_o,
  output logic                        rd_fips_o,
  input  logic                        flush_i,
  output logic [lvl_width(Depth)-1:0] lvl_o,
  output logic                        fips_err_o
);

  localparam int unsigned LvlW = lvl_width(Depth);

  typedef struct packed {
    logic             fips;
    logic [Width-1:0] data;
  } word_t;

  fetch_state_e    state_q, state_d;
  logic            edn_req_q, edn_req_d;
  logic            fips_err_q, fips_err_d;
  logic            push, pop;
  logic [LvlW-1:0] cnt;
  word_t           wdata, head;

  always_comb begin
    state_d    = state_q;
    fips_err_d = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((cnt < LvlW'(Depth)) && !flush_i) state_d = REQ;
      end
      REQ: begin
        if (edn_ack_i) begin
          state_d = IDLE;
          // A flush landing with the ack drops the word.
          if (!flush_i) begin
            if (RejectNonFips && !edn_fips_i) fips_err_d = 1'b1;
            else                              push       = 1'b1;
          end
        end else if (flush_i) begin
          // The request cannot be withdrawn; wait for its ack and drop it.
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (edn_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    edn_req_d = (state_d == REQ) || (state_d == DISCARD);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      edn_req_q  <= 1'b0;
      fips_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edn_req_q  <= edn_req_d;
      fips_err_q <= fips_err_d;
    end
  end

  assign wdata.fips = edn_fips_i;
  assign wdata.data = edn_data_i;

  prim_edn_prefetch_buf #(
    .EntryW (Width + 1),
    .Depth  (Depth)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .clr_i   (flush_i),
    .cnt_o   (cnt),
    .head_o  (head)
  );

  // Flush masks the ack so a consumer never takes a word being discarded.
  assign pop        = rd_req_i && (cnt != '0) && !flush_i;
  assign rd_ack_o   = pop;
  assign rd_data_o  = (cnt != '0) ? head.data : '0;
  assign rd_fips_o  = (cnt != '0) ? head.fips : 1'b0;
  assign lvl_o      = cnt;
  assign edn_req_o  = edn_req_q;
  assign fips_err_o = fips_err_q;

  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (edn_req_o && !edn_ack_i) |=> edn_req_o);

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (cnt != LvlW'(Depth)));

  a_ack_with_req : assert property (@(posedge clk_i) disable iff (rst_i)
    edn_ack_i |-> edn_req_o);

endmodule
